// File: rtl/dl_shift_pipe.sv
// Pipelined SLL/SRL/SRA/ROL shifter: the shift amount is consumed a slice per
// register stage (LSB slice first), with valid/ready handshakes on both ends.
module dl_shift_pipe #(
  parameter int  NUM_BITS       = 32,
  parameter int  NUM_STAGES     = 2,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [NUM_BITS-1:0]       in_a,
  input  logic [NUM_SHIFT_BITS-1:0] in_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam int SLICE_BITS = (NUM_STAGES > 0) ? (NUM_SHIFT_BITS / NUM_STAGES) : 1;

  if (NUM_STAGES < 1 || NUM_STAGES > NUM_SHIFT_BITS) begin : g_bad_stages
    $error("dl_shift_pipe: NUM_STAGES must be in 1..$clog2(NUM_BITS)");
  end
  if (NUM_BITS < 2 || (NUM_BITS & (NUM_BITS - 1)) != 0) begin : g_bad_bits
    $error("dl_shift_pipe: NUM_BITS must be a power of two >= 2");
  end

  // Bits [lo..hi] of the shift amount set, all others clear.
  function automatic logic [NUM_SHIFT_BITS-1:0] slice_mask(input int lo, input int hi);
    logic [NUM_SHIFT_BITS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SHIFT_BITS; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

  // Rotation takes the upper half of {a,a} << amt, so amt = 0 returns a unchanged.
  function automatic logic [NUM_BITS-1:0] shift_op(input logic [1:0] op,
                                                   input logic [NUM_BITS-1:0] a,
                                                   input logic [NUM_SHIFT_BITS-1:0] amt);
    logic [2*NUM_BITS-1:0] dbl;
    logic [NUM_BITS-1:0]   res;
    dbl = {a, a} << amt;
    case (op)
      OP_SLL:  res = a << amt;
      OP_SRL:  res = a >> amt;
      OP_SRA:  res = $unsigned($signed(a) >>> amt);
      OP_ROL:  res = dbl[2*NUM_BITS-1 -: NUM_BITS];
      default: res = a;
    endcase
    return res;
  endfunction

  logic advance_s;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE_BITS;
    localparam int HI = (k == NUM_STAGES - 1) ? (NUM_SHIFT_BITS - 1) : (LO + SLICE_BITS - 1);
    localparam logic [NUM_SHIFT_BITS-1:0] STAGE_MASK = slice_mask(LO, HI);

    logic                      src_valid_s;
    logic [1:0]                src_op_s;
    logic [NUM_BITS-1:0]       src_data_s;
    logic [NUM_SHIFT_BITS-1:0] src_shift_s;
    logic                      valid_r;
    logic [NUM_BITS-1:0]       data_r;

    if (k == 0) begin : g_head
      assign src_valid_s = in_valid;
      assign src_op_s    = in_op;
      assign src_data_s  = in_a;
      assign src_shift_s = in_shift;
    end else begin : g_body
      assign src_valid_s = g_stage[k-1].valid_r;
      assign src_op_s    = g_stage[k-1].g_fwd.op_r;
      assign src_data_s  = g_stage[k-1].data_r;
      assign src_shift_s = g_stage[k-1].g_fwd.shift_r;
    end

    // Stage valid always advances; data only loads for a valid entry so the
    // output holds its last result across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        data_r  <= '0;
      end else if (advance_s) begin
        valid_r <= src_valid_s;
        if (src_valid_s) begin
          data_r <= shift_op(src_op_s, src_data_s, src_shift_s & STAGE_MASK);
        end
      end
    end

    if (k < NUM_STAGES - 1) begin : g_fwd
      logic [1:0]                op_r;
      logic [NUM_SHIFT_BITS-1:0] shift_r;

      // Op and the not-yet-consumed shift bits travel alongside the data.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_r    <= 2'b00;
          shift_r <= '0;
        end else if (advance_s && src_valid_s) begin
          op_r    <= src_op_s;
          shift_r <= src_shift_s & ~STAGE_MASK;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].valid_r;
  assign out_data  = g_stage[NUM_STAGES-1].data_r;
  assign advance_s = ~out_valid | out_ready;
  assign in_ready  = advance_s;

endmodule
